vga_board_capture: RTL and testbench

- Receive-side counterpart of the Game of Life VGA output.
- Takes the 8-bit tiny-VGA pin bundle, recovers pixel timing from hsync/vsync, and samples the centre pixel of each 48x48 cell.
- Rebuilds the 8x8 board as a 64-bit word once per frame.
- Used as an on-chip/bench monitor to check displayed generations without a screen.

---
 rtl/vga_board_capture.sv | 206 ++++++++++++++++++++
 tb/tb_vga_board_capture.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_board_capture.sv
// Receive-side monitor for the Game of Life VGA output: recovers pixel timing
// from hsync/vsync, samples each cell centre and publishes the board once per frame.
module vga_board_capture #(
    parameter int H_VISIBLE       = 640,
    parameter int H_TOTAL         = 800,
    parameter int H_SYNC_START    = 656,
    parameter int V_VISIBLE       = 480,
    parameter int V_TOTAL         = 525,
    parameter int V_SYNC_START    = 490,
    parameter int CELL_SIZE       = 48,
    parameter int BOARD_W         = 8,
    parameter int BOARD_H         = 8,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 vga_in,
    output logic [BOARD_W*BOARD_H-1:0] board,
    output logic                       board_valid,
    output logic                       board_changed,
    output logic                       decode_err,
    output logic                       locked,
    output logic                       sync_err,
    output logic [15:0]                frame_cnt
);

    localparam int NCELL = BOARD_W * BOARD_H;
    localparam int H_W   = $clog2(H_TOTAL);
    localparam int V_W   = $clog2(V_TOTAL);
    localparam int CW    = $clog2(BOARD_W);
    localparam int RW    = $clog2(BOARD_H);
    localparam int IW    = $clog2(NCELL);
    localparam int X0    = (H_VISIBLE - CELL_SIZE * BOARD_W) / 2;
    localparam int Y0    = (V_VISIBLE - CELL_SIZE * BOARD_H) / 2;

    typedef enum logic [1:0] {HUNT, HLOCK, LOCKED} state_t;

    state_t           state;
    logic             hs_prev, vs_prev;
    logic [H_W-1:0]   h_cnt;
    logic [V_W-1:0]   v_cnt;
    logic             frame_ok;
    logic [NCELL-1:0] shadow;
    logic             err_acc;

    // Incremental sample-point trackers: next column x / next row y to hit.
    logic [H_W-1:0]   col_x;
    logic [CW-1:0]    col_idx;
    logic             col_done;
    logic [V_W-1:0]   row_y;
    logic [RW-1:0]    row_idx;
    logic             row_done;

    logic             hs_act, vs_act, hs_edge, vs_edge, vs_edge_eff;
    logic             h_mis, v_mis;
    logic [H_W-1:0]   h_eff, h_next;
    logic [V_W-1:0]   v_eff, v_next;
    logic             h_last, frame_start, frame_end;
    logic             col_hit, row_hit, samp;
    logic [5:0]       colour;
    logic             pix_alive, pix_bad;
    logic [IW-1:0]    cell_idx;

    assign hs_act = vga_in[7] ^ (SYNC_ACTIVE_LOW != 0);
    assign vs_act = vga_in[3] ^ (SYNC_ACTIVE_LOW != 0);
    assign hs_edge = hs_act & ~hs_prev;
    assign vs_edge = vs_act & ~vs_prev;

    // {r1,r0,g1,g0,b1,b0}
    assign colour    = {vga_in[0], vga_in[4], vga_in[1], vga_in[5], vga_in[2], vga_in[6]};
    assign pix_alive = (colour == 6'h00);
    assign pix_bad   = (colour != 6'h00) && (colour != 6'h3F);

    assign locked = (state == LOCKED);

    always_comb begin
        h_mis       = hs_edge && (state != HUNT) && (h_cnt != H_W'(H_SYNC_START));
        // An hsync mismatch wins; a coincident vsync edge is dropped entirely.
        vs_edge_eff = vs_edge && !h_mis;
        v_mis       = vs_edge_eff && (state == LOCKED) && (v_cnt != V_W'(V_SYNC_START));
        h_eff       = hs_edge ? H_W'(H_SYNC_START) : h_cnt;
        v_eff       = vs_edge_eff ? V_W'(V_SYNC_START) : v_cnt;
        h_last      = (h_eff == H_W'(H_TOTAL - 1));

        if (hs_edge)
            h_next = H_W'(H_SYNC_START + 1);
        else if (h_last)
            h_next = '0;
        else
            h_next = h_eff + 1'b1;

        if (h_last)
            v_next = (v_eff == V_W'(V_TOTAL - 1)) ? '0 : v_eff + 1'b1;
        else
            v_next = v_eff;

        frame_start = (h_eff == '0) && (v_eff == '0);
        frame_end   = (h_eff == '0) && (v_eff == V_W'(V_VISIBLE));
        col_hit     = (h_eff == col_x) && !col_done;
        row_hit     = (v_eff == row_y) && !row_done;
        samp        = (state == LOCKED) && col_hit && row_hit;
        cell_idx    = IW'(int'(row_idx) * BOARD_W + int'(col_idx));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= HUNT;
            hs_prev       <= 1'b0;
            vs_prev       <= 1'b0;
            h_cnt         <= '0;
            v_cnt         <= '0;
            frame_ok      <= 1'b0;
            shadow        <= '0;
            err_acc       <= 1'b0;
            col_x         <= H_W'(X0 + CELL_SIZE / 2);
            col_idx       <= '0;
            col_done      <= 1'b0;
            row_y         <= V_W'(Y0 + CELL_SIZE / 2);
            row_idx       <= '0;
            row_done      <= 1'b0;
            board         <= '0;
            board_valid   <= 1'b0;
            board_changed <= 1'b0;
            decode_err    <= 1'b0;
            sync_err      <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            hs_prev       <= hs_act;
            vs_prev       <= vs_act;
            h_cnt         <= h_next;
            v_cnt         <= v_next;
            board_valid   <= 1'b0;
            board_changed <= 1'b0;
            decode_err    <= 1'b0;
            sync_err      <= 1'b0;

            if (state == LOCKED && frame_start)
                frame_ok <= 1'b1;

            case (state)
                HUNT: begin
                    if (hs_edge)
                        state <= HLOCK;
                end
                HLOCK: begin
                    if (h_mis) begin
                        sync_err <= 1'b1;
                        frame_ok <= 1'b0;
                    end else if (vs_edge) begin
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (h_mis) begin
                        sync_err <= 1'b1;
                        frame_ok <= 1'b0;
                        state    <= HLOCK;
                    end else if (v_mis) begin
                        sync_err <= 1'b1;
                        frame_ok <= 1'b0;
                    end
                end
                default: state <= HUNT;
            endcase

            if (h_eff == '0) begin
                col_x    <= H_W'(X0 + CELL_SIZE / 2);
                col_idx  <= '0;
                col_done <= 1'b0;
            end else if (col_hit) begin
                col_x    <= col_x + H_W'(CELL_SIZE);
                col_idx  <= col_idx + 1'b1;
                col_done <= (col_idx == CW'(BOARD_W - 1));
            end

            // Row advances on the last pixel of a sampling line.
            if (frame_start) begin
                row_y    <= V_W'(Y0 + CELL_SIZE / 2);
                row_idx  <= '0;
                row_done <= 1'b0;
            end else if (h_last && row_hit) begin
                row_y    <= row_y + V_W'(CELL_SIZE);
                row_idx  <= row_idx + 1'b1;
                row_done <= (row_idx == RW'(BOARD_H - 1));
            end

            if (frame_start) begin
                shadow  <= '0;
                err_acc <= 1'b0;
            end else if (samp) begin
                shadow[cell_idx] <= pix_alive;
                if (pix_bad)
                    err_acc <= 1'b1;
            end

            if (frame_end && state == LOCKED && frame_ok) begin
                board         <= shadow;
                board_changed <= (shadow != board);
                decode_err    <= err_acc;
                board_valid   <= 1'b1;
                frame_cnt     <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_board_capture.sv
// Directed bench for vga_board_capture using a scaled-down raster (56x42 total)
// so several whole frames fit in a short run; cell geometry keeps the 8x8 board.
module tb_vga_board_capture;

    localparam int HV = 40, HT = 56, HS = 44;
    localparam int VV = 36, VT = 42, VS = 38;
    localparam int CS = 4,  X0 = 4,  Y0 = 2;
    localparam logic [63:0] GOLD = 64'h0030_0048_0048_0048;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  vga_in;
    logic [63:0] board;
    logic        board_valid, board_changed, decode_err, locked, sync_err;
    logic [15:0] frame_cnt;

    int src_h, src_v, last_h, last_v;
    int n_pulse, n_serr;
    int errors, checks;
    logic [63:0] pattern;
    bit          early;
    bit          ovr_en;
    logic [5:0]  ovr_col;

    vga_board_capture #(
        .H_VISIBLE(HV), .H_TOTAL(HT), .H_SYNC_START(HS),
        .V_VISIBLE(VV), .V_TOTAL(VT), .V_SYNC_START(VS),
        .CELL_SIZE(CS), .BOARD_W(8), .BOARD_H(8), .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .vga_in(vga_in),
        .board(board), .board_valid(board_valid), .board_changed(board_changed),
        .decode_err(decode_err), .locked(locked), .sync_err(sync_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int h, input int v);
        logic hs, vs;
        logic [5:0] col;
        int idx;
        if (early && v == 10) hs = (h >= HS - 3) && (h < HS + 1);
        else                  hs = (h >= HS) && (h < HS + 4);
        vs  = (v >= VS) && (v < VS + 2);
        col = 6'h00;
        if (h < HV && v < VV) begin
            col = 6'h3F;
            if (h >= X0 && h < X0 + CS * 8 && v >= Y0 && v < Y0 + CS * 8) begin
                idx = ((v - Y0) / CS) * 8 + (h - X0) / CS;
                col = pattern[idx] ? 6'h00 : 6'h3F;
            end
        end
        // cell 9 sample point
        if (ovr_en && h == X0 + CS + CS / 2 && v == Y0 + CS + CS / 2) col = ovr_col;
        return {~hs, col[0], col[2], col[4], ~vs, col[1], col[3], col[5]};
    endfunction

    task automatic tick();
        vga_in = pix(src_h, src_v);
        @(posedge clk);
        #1;
        last_h = src_h;
        last_v = src_v;
        if (board_valid) n_pulse++;
        if (sync_err) n_serr++;
        src_h++;
        if (src_h == HT) begin
            src_h = 0;
            src_v = (src_v == VT - 1) ? 0 : src_v + 1;
        end
    endtask

    task automatic run_until(input int h, input int v);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(last_h == h && last_v == v) && n < 3 * HT * VT);
        if (!(last_h == h && last_v == v)) begin
            checks++; errors++;
            $display("FAIL run_until: reached (%0d,%0d) want (%0d,%0d)", last_h, last_v, h, v);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        src_h = 10; src_v = 5;
        repeat (4) tick();
        checks++; if (board !== 64'h0) begin errors++; $display("FAIL reset_board: got %h want 0", board); end
        checks++; if (board_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", board_valid); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b want 0", sync_err); end
        reset = 1'b0;
    endtask

    task automatic test_lock();
        run_until(HS, 5);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL hlock_locked: got %b want 0", locked); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL hunt_sync_err: got %b want 0", sync_err); end
        run_until(HT - 1, VS - 1);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL pre_vsync_locked: got %b want 0", locked); end
        tick();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL vsync_locked: got %b want 1", locked); end
    endtask

    task automatic test_golden();
        n_pulse = 0;
        run_until(0, VV);
        checks++; if (board_valid !== 1'b1) begin errors++; $display("FAIL gold1_valid: got %b want 1", board_valid); end
        checks++; if (n_pulse !== 1) begin errors++; $display("FAIL gold1_pulses: got %0d want 1", n_pulse); end
        checks++; if (board !== GOLD) begin errors++; $display("FAIL gold1_board: got %h want %h", board, GOLD); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL gold1_frame_cnt: got %0d want 1", frame_cnt); end
        checks++; if (board_changed !== 1'b1) begin errors++; $display("FAIL gold1_changed: got %b want 1", board_changed); end
        checks++; if (decode_err !== 1'b0) begin errors++; $display("FAIL gold1_decode_err: got %b want 0", decode_err); end
        tick();
        checks++; if (board_valid !== 1'b0) begin errors++; $display("FAIL gold1_pulse_width: got %b want 0", board_valid); end
        checks++; if (board_changed !== 1'b0) begin errors++; $display("FAIL gold1_changed_after: got %b want 0", board_changed); end
        run_until(0, VV);
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL gold2_frame_cnt: got %0d want 2", frame_cnt); end
        checks++; if (board_valid !== 1'b1 || board_changed !== 1'b0) begin errors++; $display("FAIL gold2_unchanged: got valid=%b changed=%b want 1/0", board_valid, board_changed); end
    endtask

    task automatic test_toggle();
        pattern = GOLD | 64'h1;
        run_until(0, VV);
        checks++; if (board !== (GOLD | 64'h1)) begin errors++; $display("FAIL toggle_board: got %h want %h", board, GOLD | 64'h1); end
        checks++; if (board_changed !== 1'b1) begin errors++; $display("FAIL toggle_changed: got %b want 1", board_changed); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL toggle_frame_cnt: got %0d want 3", frame_cnt); end
    endtask

    task automatic test_sync_err();
        int p0, s0;
        early = 1'b1;
        s0 = n_serr;
        run_until(HS - 3, 10);
        checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL early_sync_err: got %b want 1", sync_err); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL early_locked: got %b want 0", locked); end
        p0 = n_pulse;
        run_until(0, VV);
        early = 1'b0;
        checks++; if (n_pulse !== p0 || board_valid !== 1'b0) begin errors++; $display("FAIL early_no_pulse: got pulses=%0d want 0", n_pulse - p0); end
        // Line 11 arrives 3 pixels late relative to the realigned counter: a second mismatch.
        checks++; if (n_serr - s0 !== 2) begin errors++; $display("FAIL early_err_count: got %0d want 2", n_serr - s0); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL early_frame_cnt: got %0d want 3", frame_cnt); end
        run_until(0, VV);
        checks++; if (board_valid !== 1'b1) begin errors++; $display("FAIL recover_valid: got %b want 1", board_valid); end
        checks++; if (board !== (GOLD | 64'h1)) begin errors++; $display("FAIL recover_board: got %h want %h", board, GOLD | 64'h1); end
        checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL recover_frame_cnt: got %0d want 4", frame_cnt); end
    endtask

    task automatic test_decode();
        pattern = GOLD | 64'h1 | (64'h1 << 9);
        ovr_en  = 1'b1;
        ovr_col = 6'h34;
        run_until(0, VV);
        ovr_en = 1'b0;
        checks++; if (board_valid !== 1'b1 || decode_err !== 1'b1) begin errors++; $display("FAIL orange_decode_err: got valid=%b err=%b want 1/1", board_valid, decode_err); end
        checks++; if (board[9] !== 1'b0) begin errors++; $display("FAIL orange_cell9: got %b want 0", board[9]); end
        checks++; if (board !== (GOLD | 64'h1)) begin errors++; $display("FAIL orange_board: got %h want %h", board, GOLD | 64'h1); end
        run_until(0, VV);
        checks++; if (board !== pattern) begin errors++; $display("FAIL clean_board: got %h want %h", board, pattern); end
        checks++; if (decode_err !== 1'b0 || board_changed !== 1'b1) begin errors++; $display("FAIL clean_flags: got err=%b changed=%b want 0/1", decode_err, board_changed); end
        checks++; if (frame_cnt !== 16'd6) begin errors++; $display("FAIL clean_frame_cnt: got %0d want 6", frame_cnt); end
    endtask

    task automatic test_reset_mid();
        int p0;
        run_until(5, 20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (board !== 64'h0 || frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_clear: got board=%h cnt=%0d want 0/0", board, frame_cnt); end
        checks++; if (locked !== 1'b0 || board_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got locked=%b valid=%b want 0/0", locked, board_valid); end
        p0 = n_pulse;
        run_until(0, VV);
        checks++; if (board_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_partial: got %b want 0", board_valid); end
        run_until(0, VV);
        checks++; if (board_valid !== 1'b1 || n_pulse - p0 !== 1) begin errors++; $display("FAIL resync_valid: got valid=%b pulses=%0d want 1/1", board_valid, n_pulse - p0); end
        checks++; if (board !== pattern) begin errors++; $display("FAIL resync_board: got %h want %h", board, pattern); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL resync_frame_cnt: got %0d want 1", frame_cnt); end
    endtask

    initial begin
        errors = 0; checks = 0;
        n_pulse = 0; n_serr = 0;
        pattern = GOLD;
        early = 1'b0; ovr_en = 1'b0; ovr_col = 6'h00;
        reset = 1'b1;
        vga_in = 8'h88;
        test_reset();
        test_lock();
        test_golden();
        test_toggle();
        test_sync_err();
        test_decode();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
